uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the UART receiver datapath. Synchronizes the raw serial line and detects start bits. Generates one mid-bit `rx_en` strobe per bit period to step the receiver. Captures each completed frame, with its parity and framing status, into a small FIFO drained by the host over a valid/ready handshake.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; even, >= 4.
- `FIFO_DEPTH`, 4: frame FIFO entries; power of two, >= 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_in`  in  1  raw asynchronous serial line; idles high.
- `rx_line`  out  1  synchronized line, fed to the receiver's `rx`.
- `rx_en`  out  1  one-cycle bit strobe to the receiver.
- `rcv_busy`  in  1  receiver busy flag.
- `rcv_data`  in  8  receiver data output.
- `rcv_error`  in  1  receiver parity-error flag.
- `enable`  in  1  allows new frames to start.
- `data`  out  8  head-of-FIFO data byte.
- `parity_err`  out  1  head-of-FIFO parity error.
- `frame_err`  out  1  head-of-FIFO framing error (stop bit sampled 0).
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  host accepts the head entry.
- `overrun`  out  1  sticky: a frame was dropped because the FIFO was full.
- `clear_overrun`  in  1  clears `overrun`.

## Operation
- **Synchronizer.** Two-flop synchronizer from `rx_in` to `rx_line`. Both flops reset to 1.
- **Frame format.** Start bit, 8 receiver bits, stop bit: 10 bit periods and exactly 10 `rx_en` strobes per accepted frame.
- **State `IDLE`.**
  - `rx_en` = 0.
  - Moves to `HUNT` when `enable`=1 and a falling edge is seen on `rx_line` (previous 1, current 0).
  - Call that cycle t0. The bit-period counter clears.
- **State `HUNT`.**
  - Counts to `CLKS_PER_BIT/2`.
  - At t0+`CLKS_PER_BIT/2`, if `rx_line`=0: pulse `rx_en` (strobe 0) and go to `SAMPLE`.
  - If `rx_line`=1 at that cycle: false start. No strobe; return to `IDLE`.
- **State `SAMPLE`.**
  - Strobe k (k=1..9) pulses at t0+`CLKS_PER_BIT/2`+k·`CLKS_PER_BIT`.
  - A 4-bit strobe counter tracks k.
  - At strobe 9 the controller latches the stop bit: `stop_bad` = ~`rx_line`. Then go to `CAPTURE`.
- **State `CAPTURE`** (one cycle).
  - Push {`stop_bad`, `rcv_error`, `rcv_data`} into the FIFO.
  - If `rcv_busy`=1 in this cycle, the entry's frame_err is forced to 1.
  - Go to `IDLE`.
  - A new start requires a fresh falling edge, so a stuck-low line never retriggers.
- **`enable` deasserted.** Mid-frame deassertion does not abort the frame; it only blocks the `IDLE`→`HUNT` transition.
- **FIFO.**
  - Read/write pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap modulo 2·`FIFO_DEPTH`.
  - Full when the pointer MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - Pop occurs when `valid` && `ready`.
  - Push while full without a simultaneous pop: the frame is dropped, the FIFO is unchanged, and `overrun` is set.
  - Push and pop in the same cycle while full: both happen; count unchanged; no overrun.
  - Pop while empty is ignored.
- **Overrun flag.** `clear_overrun` clears `overrun`. If `clear_overrun` and a dropping push coincide, set wins (`overrun` stays 1).
- **Output register.** `data`/`parity_err`/`frame_err` show the entry at the read pointer. They are don't-care when `valid`=0, but are driven to 0 after reset.

## Timing
- **Reset values** (reset has priority over all inputs, mid-frame included):
  - State `IDLE`; counters 0; FIFO empty.
  - `rx_line`=1, `rx_en`=0, `valid`=0.
  - `data`=0, `parity_err`=0, `frame_err`=0, `overrun`=0.
- **Synchronizer latency.** `rx_in`→`rx_line`: 2 cycles.
- **Strobe shape.** `rx_en` is high for exactly one cycle per strobe. It is never high in `IDLE` or `CAPTURE`.
- **Frame timing.**
  - Strobe 9 at t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
  - Push 1 cycle later.
  - `valid` rises 2 cycles after strobe 9 (registered FIFO; no fall-through).
- **Pop timing.** After a pop, the next entry (or `valid`=0) appears the following cycle.
- **Throughput.** One frame per ≥ 10·`CLKS_PER_BIT`+2 cycles.

## Test plan
- **Clean frame.** `CLKS_PER_BIT`=16, `ready`=0; send byte with stop=1, line bits chosen so the receiver yields `rcv_data`=0xA5, `rcv_error`=0 → exactly 10 strobes spaced 16 cycles apart, first at t0+8; `valid` at strobe9+2; `data`=0xA5, `parity_err`=0, `frame_err`=0.
- **False start.** 4-cycle low glitch on `rx_in` → no `rx_en` pulse; state returns to `IDLE`; `valid` stays 0.
- **Framing error.** Stop bit driven 0 → entry has `frame_err`=1. With `rx_in` held low afterwards, no new frame starts until the line returns high and falls again.
- **FIFO overrun.** With `FIFO_DEPTH`=4, send 5 frames (0x01–0x05) with `ready`=0 → `overrun`=1, FIFO holds 0x01–0x04. Drain with `ready`=1 → 0x01–0x04 in order, then `valid`=0. `clear_overrun` → `overrun`=0.
- **Full with simultaneous pop.** FIFO full and `ready`=1 in the push cycle → new frame accepted, `overrun` stays 0.
- **Reset mid-frame.** Assert `reset` during strobe 4 → next cycle all outputs at reset values, no further strobes. A subsequent clean frame with 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Host-side frame FIFO port: head-of-queue entry with a valid/ready handshake.
// The controller drives the head entry through the master modport; the host
// consumes it through the slave modport.
interface uart_rx_ctrl_if;
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;
    logic       valid;
    logic       ready;

    modport master (
        output data,
        output parity_err,
        output frame_err,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  parity_err,
        input  frame_err,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller.
// Synchronizes the serial line, hunts for a start bit, issues one mid-bit
// rx_en strobe per bit period, and queues each finished frame (data, parity
// and framing status) into a small FIFO that the host drains.
// rx_en is a registered output, so each strobe decision is made one cycle
// ahead: the start-bit check looks at the first synchronizer flop, which
// holds the value rx_line will carry in the strobe cycle.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_in,
    output logic        rx_line,
    output logic        rx_en,
    input  logic        rcv_busy,
    input  logic [7:0]  rcv_data,
    input  logic        rcv_error,
    input  logic        enable,
    uart_rx_ctrl_if.master host,
    output logic        overrun,
    input  logic        clear_overrun
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    localparam logic [CNT_W-1:0] HUNT_LAST   = CNT_W'(HALF - 2);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_STROBE = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        SAMPLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Line synchronizer and edge history
    logic             sync0_r;
    logic             sync1_r;
    logic             prev_r;

    // Frame sequencing
    state_t           state_r;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       bit_cnt_r;
    logic [3:0]       bit_cnt_nxt;
    logic             stop_bad_r;
    logic             stop_bad_nxt;
    logic             rx_en_r;
    logic             rx_en_nxt;

    // Frame FIFO
    logic [9:0]       mem_r [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [9:0]       head_r;
    logic [9:0]       head_nxt;
    logic             valid_r;
    logic             valid_nxt;
    logic             overrun_r;

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             write_s;
    logic             drop_s;
    logic [9:0]       entry_s;

    assign rx_line         = sync1_r;
    assign rx_en           = rx_en_r;
    assign overrun         = overrun_r;
    assign host.data       = head_r[7:0];
    assign host.parity_err = head_r[8];
    assign host.frame_err  = head_r[9];
    assign host.valid      = valid_r;

    // Synchronizer, edge history and sequencer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_r    <= 1'b1;
            sync1_r    <= 1'b1;
            prev_r     <= 1'b1;
            state_r    <= IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= 4'd0;
            stop_bad_r <= 1'b0;
            rx_en_r    <= 1'b0;
        end else begin
            sync0_r    <= rx_in;
            sync1_r    <= sync0_r;
            prev_r     <= sync1_r;
            state_r    <= state_nxt;
            cnt_r      <= cnt_nxt;
            bit_cnt_r  <= bit_cnt_nxt;
            stop_bad_r <= stop_bad_nxt;
            rx_en_r    <= rx_en_nxt;
        end
    end

    // Next-state, counter and strobe decisions for the frame sequencer
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        bit_cnt_nxt  = bit_cnt_r;
        stop_bad_nxt = stop_bad_r;
        rx_en_nxt    = 1'b0;
        case (state_r)
            IDLE: begin
                // Only a genuine 1->0 transition starts a frame, so a line
                // stuck low never retriggers.
                if (enable && prev_r && !sync1_r) begin
                    state_nxt = HUNT;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HUNT: begin
                if (cnt_r == HUNT_LAST) begin
                    if (!sync0_r) begin
                        rx_en_nxt   = 1'b1;
                        state_nxt   = SAMPLE;
                        cnt_nxt     = '0;
                        bit_cnt_nxt = 4'd0;
                    end else begin
                        // Line back high at mid-start-bit: glitch, not a frame
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (rx_en_r && (bit_cnt_r == LAST_STROBE)) begin
                    // Strobe 9 lands in the middle of the stop bit
                    state_nxt    = CAPTURE;
                    stop_bad_nxt = ~sync1_r;
                    cnt_nxt      = '0;
                end else if (cnt_r == BIT_LAST) begin
                    rx_en_nxt   = 1'b1;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = bit_cnt_r + 4'd1;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            CAPTURE: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                bit_cnt_nxt = 4'd0;
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                bit_cnt_nxt = 4'd0;
            end
        endcase
    end

    // FIFO control: push/pop arbitration, pointer update and next head entry
    always_comb begin
        push_s  = (state_r == CAPTURE);
        pop_s   = valid_r && host.ready;
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        write_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;
        entry_s = {stop_bad_r | rcv_busy, rcv_error, rcv_data};

        if (write_s) begin
            wr_ptr_nxt = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt = rd_ptr_r;
        end

        valid_nxt = (wr_ptr_nxt != rd_ptr_nxt);

        // The slot being written this cycle is only the new head when it is
        // the sole entry, so forward it instead of reading stale memory.
        if (!valid_nxt) begin
            head_nxt = 10'd0;
        end else if (write_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
            head_nxt = entry_s;
        end else begin
            head_nxt = mem_r[rd_ptr_nxt[AW-1:0]];
        end
    end

    // FIFO pointers and registered head-of-queue outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            head_r   <= 10'd0;
            valid_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt;
            rd_ptr_r <= rd_ptr_nxt;
            head_r   <= head_nxt;
            valid_r  <= valid_nxt;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    // Sticky overrun flag; a dropped frame outranks a clear request
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (clear_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule
